rl_ram_1rw_port: RTL and testbench
==================================

RL_RAM_1RW_PORT -- requirements
Module: rl_ram_1rw_port

Interface
REQ-001 The block SHALL have parameter ABITS, default 10, the RAM word-address width.
REQ-002 The block SHALL have parameter DBITS, default 32, the data width; BBITS=(DBITS+7)/8 is the byte-enable width.
REQ-003 The block SHALL have these ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_addr_i  in  ABITS  word address.
- req_we_i  in  1  1=write, 0=read.
- req_be_i  in  BBITS  byte enables.
- req_wdata_i  in  DBITS  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o.
- rsp_rdata_o  out  DBITS  read data.
- rsp_we_o  out  1  response belongs to a write.
- ram_addr_o  out  ABITS  to RAM addr_i.
- ram_we_o  out  1  to RAM we_i.
- ram_be_o  out  BBITS  to RAM be_i.
- ram_din_o  out  DBITS  to RAM din_i.
- ram_dout_i  in  DBITS  from RAM dout_o; 1-cycle registered read.
REQ-004 The block SHALL use one clock, clk_i; reset rst_ni is synchronous and active-low.

Function
REQ-005 The block SHALL accept a request (accept = req_valid_i & req_ready_o & rst_ni) on a rising edge and drive the RAM combinationally in that same cycle.
REQ-006 ram_addr_o, ram_be_o and ram_din_o SHALL equal req_addr_i, req_be_i and req_wdata_i at all times; ram_we_o SHALL equal accept & req_we_i.
REQ-007 Every accepted request, read or write, SHALL produce exactly one response, strictly in acceptance order.
REQ-008 An in-flight flag SHALL be set for the cycle after an accept; in that cycle ram_dout_i SHALL be captured into the response FIFO.
REQ-009 The captured entry SHALL hold rsp_we_o = the request's req_we_i; rsp_rdata_o SHALL be ram_dout_i for reads and all-zero for writes.
REQ-010 The response FIFO SHALL have depth 3 and occupancy count occ in 0..3; rsp_valid_o = (occ != 0).
REQ-011 The FIFO head SHALL drive rsp_rdata_o and rsp_we_o directly, with no bypass from ram_dout_i; read latency from accept to earliest rsp_valid_o SHALL be 2 cycles.
REQ-012 req_ready_o SHALL equal rst_ni & ((occ + inflight) <= 2), with no combinational path from rsp_ready_i or req_valid_i.
REQ-013 With rsp_ready_i held high, the block SHALL sustain one accept per cycle indefinitely.
REQ-014 While rsp_valid_o=1 and rsp_ready_i=0, rsp_rdata_o and rsp_we_o SHALL hold stable.
REQ-015 A push (from the in-flight capture) and a pop (rsp_valid_o & rsp_ready_i) in the same cycle SHALL leave occ unchanged and preserve order.
REQ-016 The FIFO pointers SHALL wrap modulo 3.
REQ-017 The design SHALL guarantee that occ never exceeds 3 and the in-flight capture never finds the FIFO full.
REQ-018 Partial byte enables, including all-zero, SHALL pass through unchanged; a write with be=0 still produces a response.

Reset
REQ-019 While rst_ni=0 at a clock edge, the block SHALL clear inflight, occ and the pointers; the outputs SHALL then be rsp_valid_o=0, rsp_we_o=0, rsp_rdata_o=0.
REQ-020 While rst_ni=0, req_ready_o=0 and ram_we_o=0, so no write is performed.
REQ-021 On reset mid-operation, the block SHALL discard in-flight and buffered responses; RAM writes already committed are not reverted.
REQ-022 In the first cycle after rst_ni rises, req_ready_o SHALL be 1.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write addr 5, data 0xDEADBEEF, be 0xF, then read addr 5 -> write response (rsp_we_o=1, rdata 0); read response rdata 0xDEADBEEF, 2 cycles after the read accept.
- Write 0x11223344 to addr 7, then be=0x2 data 0x0000AA00, then read addr 7 -> rdata 0x1122AA44.
- 16 back-to-back reads, addr 0..15, with rsp_ready_i=1 -> req_ready_o stays high; 16 in-order responses.
- Hold rsp_ready_i=0 and issue reads -> exactly 3 accepts, then req_ready_o=0; rsp data stable; release -> 3 responses in order; ready returns.
- Assert rst_ni=0 for 1 cycle with occ=2 and a write presented -> rsp_valid_o=0 next cycle; RAM location unchanged; req_ready_o=1 after release.
- Random valid/ready traffic checked against a scoreboard RAM model -> no lost, duplicated or reordered responses.

Source files
------------

// File: rtl/rl_ram_1rw_port.sv
`default_nettype none
// ============================================================================
// Module      : rl_ram_1rw_port
// Description : Valid/ready request/response front end for a single-port RAM
//               with a 1-cycle registered read. Requests drive the RAM
//               combinationally on accept; the RAM output is captured one
//               cycle later into a 3-entry response FIFO whose head drives
//               the response port. Every request (read or write) yields
//               exactly one response, in acceptance order.
// Ports       :
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   req_valid_i  request valid          req_ready_o  request accepted
//   req_addr_i   word address           req_we_i     1=write, 0=read
//   req_be_i     byte enables           req_wdata_i  write data
//   rsp_valid_o  response valid         rsp_ready_i  response consumed
//   rsp_rdata_o  read data (0 for writes)
//   rsp_we_o     response belongs to a write
//   ram_addr_o / ram_we_o / ram_be_o / ram_din_o  to RAM
//   ram_dout_i   from RAM, valid the cycle after the access
// Revision    : 1.0 - initial release
// ============================================================================
module rl_ram_1rw_port #(
  parameter int ABITS = 10,
  parameter int DBITS = 32,
  localparam int BBITS = (DBITS + 7) / 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [ABITS-1:0] req_addr_i,
  input  logic             req_we_i,
  input  logic [BBITS-1:0] req_be_i,
  input  logic [DBITS-1:0] req_wdata_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DBITS-1:0] rsp_rdata_o,
  output logic             rsp_we_o,
  output logic [ABITS-1:0] ram_addr_o,
  output logic             ram_we_o,
  output logic [BBITS-1:0] ram_be_o,
  output logic [DBITS-1:0] ram_din_o,
  input  logic [DBITS-1:0] ram_dout_i
);

  localparam logic [1:0] c_LAST_IDX = 2'd2;  // highest FIFO index (depth 3)
  localparam logic [2:0] c_MAX_LOAD = 3'd2;  // accept only if a slot stays free

  // Pointer increment wrapping modulo 3.
  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == c_LAST_IDX) ? 2'd0 : p + 2'd1;
  endfunction

  logic             inflight_q, inflight_d;
  logic             inflight_we_q, inflight_we_d;
  logic [1:0]       wptr_q, wptr_d;
  logic [1:0]       rptr_q, rptr_d;
  logic [1:0]       occ_q, occ_d;
  logic [DBITS-1:0] fifo_data_q [3];
  logic             fifo_we_q   [3];

  logic [2:0]       w_load;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;

  // Credit check counts the in-flight access as already occupying a slot,
  // so the capture one cycle later can never find the FIFO full. It only
  // looks at registered state, so ready has no path from valid or rsp_ready.
  assign w_load      = {1'b0, occ_q} + {2'b00, inflight_q};
  assign req_ready_o = rst_ni & (w_load <= c_MAX_LOAD);
  assign w_accept    = req_valid_i & req_ready_o;

  assign ram_addr_o  = req_addr_i;
  assign ram_be_o    = req_be_i;
  assign ram_din_o   = req_wdata_i;
  assign ram_we_o    = w_accept & req_we_i;

  assign w_push      = inflight_q;
  assign rsp_valid_o = (occ_q != 2'd0);
  assign w_pop       = rsp_valid_o & rsp_ready_i;

  // Head entry drives the response directly; no bypass from ram_dout_i.
  assign rsp_rdata_o = fifo_data_q[rptr_q];
  assign rsp_we_o    = fifo_we_q[rptr_q];

  always_comb begin
    inflight_d    = w_accept;
    inflight_we_d = w_accept & req_we_i;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    occ_d         = occ_q;
    if (w_push) begin
      wptr_d = wrap_inc(wptr_q);
    end
    if (w_pop) begin
      rptr_d = wrap_inc(rptr_q);
    end
    unique case ({w_push, w_pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      inflight_q    <= 1'b0;
      inflight_we_q <= 1'b0;
      wptr_q        <= 2'd0;
      rptr_q        <= 2'd0;
      occ_q         <= 2'd0;
      // Entries are cleared so the head reads as zero straight after reset.
      for (int i = 0; i < 3; i++) begin
        fifo_data_q[i] <= '0;
        fifo_we_q[i]   <= 1'b0;
      end
    end else begin
      inflight_q    <= inflight_d;
      inflight_we_q <= inflight_we_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      occ_q         <= occ_d;
      if (w_push) begin
        // Writes respond with zero data rather than the RAM's read-back.
        fifo_data_q[wptr_q] <= inflight_we_q ? '0 : ram_dout_i;
        fifo_we_q[wptr_q]   <= inflight_we_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rl_ram_1rw_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_rl_ram_1rw_port
// Description : Self-checking bench for rl_ram_1rw_port. Includes a
//               behavioural 1-cycle-read RAM and a queue-based scoreboard
//               holding the expected response for each accepted request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rl_ram_1rw_port;

  localparam int ABITS = 10;
  localparam int DBITS = 32;
  localparam int BBITS = 4;
  localparam int WORDS = 1 << ABITS;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [ABITS-1:0] req_addr_i;
  logic             req_we_i;
  logic [BBITS-1:0] req_be_i;
  logic [DBITS-1:0] req_wdata_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [DBITS-1:0] rsp_rdata_o;
  logic             rsp_we_o;
  logic [ABITS-1:0] ram_addr_o;
  logic             ram_we_o;
  logic [BBITS-1:0] ram_be_o;
  logic [DBITS-1:0] ram_din_o;
  logic [DBITS-1:0] ram_dout_i;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_i = ~clk_i;

  rl_ram_1rw_port #(.ABITS(ABITS), .DBITS(DBITS)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_we_i    (req_we_i),
    .req_be_i    (req_be_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_we_o    (rsp_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_we_o    (ram_we_o),
    .ram_be_o    (ram_be_o),
    .ram_din_o   (ram_din_o),
    .ram_dout_i  (ram_dout_i)
  );

  function automatic logic [DBITS-1:0] init_val(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  // Behavioural RAM: byte-enabled write, registered read (old data).
  logic             preload;
  logic [DBITS-1:0] ram_mem [WORDS];
  always @(posedge clk_i) begin
    if (preload) begin
      for (int i = 0; i < WORDS; i++) ram_mem[i] <= init_val(i);
    end else begin
      if (ram_we_o)
        for (int b = 0; b < BBITS; b++)
          if (ram_be_o[b]) ram_mem[ram_addr_o][8*b +: 8] <= ram_din_o[8*b +: 8];
      ram_dout_i <= ram_mem[ram_addr_o];
    end
  end

  // Scoreboard: reference memory plus queue of expected responses.
  typedef struct packed { logic we; logic [DBITS-1:0] data; } rsp_t;
  rsp_t             exp_q [$];
  logic [DBITS-1:0] ref_mem [WORDS];

  initial begin : monitor
    rsp_t e;
    for (int i = 0; i < WORDS; i++) ref_mem[i] = init_val(i);
    forever begin
      @(posedge clk_i);
      if (rst_ni !== 1'b1) begin
        exp_q.delete();
      end else begin
        if (rsp_valid_o === 1'b1 && rsp_ready_i === 1'b1) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL sb_spurious: got we=%b rdata=%h, want no response", rsp_we_o, rsp_rdata_o);
          end else begin
            e = exp_q.pop_front();
            if (rsp_we_o !== e.we || rsp_rdata_o !== e.data) begin
              n_fails++;
              $display("FAIL sb_order: got we=%b rdata=%h, want we=%b rdata=%h",
                       rsp_we_o, rsp_rdata_o, e.we, e.data);
            end
          end
        end
        if (req_valid_i === 1'b1 && req_ready_o === 1'b1) begin
          e.we   = req_we_i;
          e.data = req_we_i ? '0 : ref_mem[req_addr_i];
          exp_q.push_back(e);
          if (req_we_i)
            for (int b = 0; b < BBITS; b++)
              if (req_be_i[b]) ref_mem[req_addr_i][8*b +: 8] = req_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Present a request at a negedge and return at the posedge it is accepted.
  task automatic do_req(input logic we, input logic [ABITS-1:0] addr,
                        input logic [BBITS-1:0] be, input logic [DBITS-1:0] data);
    bit got = 1'b0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_be_i = be; req_wdata_i = data;
    for (int n = 0; n < 20; n++) begin
      if (req_ready_o === 1'b1) begin got = 1'b1; break; end
      @(negedge clk_i);
    end
    n_checks++;
    if (!got) begin
      n_fails++;
      $display("FAIL req_accept_timeout: got ready=%b, want 1 within 20 cycles", req_ready_o);
    end
    @(posedge clk_i);
  endtask

  // Drop valid and wait for rsp_valid; lat counts cycles from the accept edge.
  task automatic wait_rsp(output bit ok, output int lat);
    ok = 1'b0; lat = 0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid_o === 1'b1) begin ok = 1'b1; lat = n + 1; break; end
      @(negedge clk_i);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 10'd3;
    req_be_i = 4'hF; req_wdata_i = 32'h0BAD_F00D;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_checks += 5;
    if (rsp_valid_o !== 1'b0) begin n_fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
    if (rsp_we_o !== 1'b0) begin n_fails++; $display("FAIL reset_rsp_we: got %b want 0", rsp_we_o); end
    if (rsp_rdata_o !== 32'h0) begin n_fails++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata_o); end
    if (req_ready_o !== 1'b0) begin n_fails++; $display("FAIL reset_req_ready: got %b want 0", req_ready_o); end
    if (ram_we_o !== 1'b0) begin n_fails++; $display("FAIL reset_ram_we: got %b want 0", ram_we_o); end
    rst_ni = 1'b1; req_valid_i = 1'b0;
    #1;
    n_checks++;
    if (req_ready_o !== 1'b1) begin n_fails++; $display("FAIL reset_release_ready: got %b want 1", req_ready_o); end
  endtask

  task automatic test_write_read();
    bit ok; int lat;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 10'd5; req_be_i = 4'hF; req_wdata_i = 32'hDEAD_BEEF;
    #1;
    n_checks++;
    if (ram_we_o !== 1'b1 || ram_addr_o !== 10'd5 || ram_be_o !== 4'hF || ram_din_o !== 32'hDEAD_BEEF) begin
      n_fails++;
      $display("FAIL ram_drive: got we=%b addr=%0d be=%h din=%h, want 1/5/f/deadbeef",
               ram_we_o, ram_addr_o, ram_be_o, ram_din_o);
    end
    @(posedge clk_i);
    wait_rsp(ok, lat);
    n_checks++;
    if (!ok || rsp_we_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
      n_fails++;
      $display("FAIL wr_rsp: got ok=%b we=%b rdata=%h, want 1/1/0", ok, rsp_we_o, rsp_rdata_o);
    end
    do_req(1'b0, 10'd5, 4'hF, 32'h0);
    wait_rsp(ok, lat);
    n_checks += 2;
    if (lat !== 2) begin n_fails++; $display("FAIL rd_latency: got %0d want 2", lat); end
    if (!ok || rsp_we_o !== 1'b0 || rsp_rdata_o !== 32'hDEAD_BEEF) begin
      n_fails++;
      $display("FAIL rd_rsp: got ok=%b we=%b rdata=%h, want 1/0/deadbeef", ok, rsp_we_o, rsp_rdata_o);
    end
  endtask

  task automatic test_partial_be();
    bit ok; int lat;
    do_req(1'b1, 10'd7, 4'hF, 32'h1122_3344);
    wait_rsp(ok, lat);
    do_req(1'b1, 10'd7, 4'h2, 32'h0000_AA00);
    wait_rsp(ok, lat);
    do_req(1'b1, 10'd9, 4'h0, 32'hFFFF_FFFF);
    wait_rsp(ok, lat);
    n_checks++;
    if (!ok || rsp_we_o !== 1'b1 || rsp_rdata_o !== 32'h0) begin
      n_fails++;
      $display("FAIL be0_rsp: got ok=%b we=%b rdata=%h, want 1/1/0", ok, rsp_we_o, rsp_rdata_o);
    end
    do_req(1'b0, 10'd7, 4'hF, 32'h0);
    wait_rsp(ok, lat);
    n_checks++;
    if (!ok || rsp_rdata_o !== 32'h1122_AA44) begin
      n_fails++;
      $display("FAIL partial_be: got ok=%b rdata=%h, want 1/1122aa44", ok, rsp_rdata_o);
    end
    do_req(1'b0, 10'd9, 4'hF, 32'h0);
    wait_rsp(ok, lat);
    n_checks++;
    if (!ok || rsp_rdata_o !== init_val(9)) begin
      n_fails++;
      $display("FAIL be0_nowrite: got ok=%b rdata=%h, want 1/%h", ok, rsp_rdata_o, init_val(9));
    end
  endtask

  task automatic test_back_to_back();
    int rcount = 0;
    rsp_ready_i = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk_i);
      if (i < 16) begin
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = ABITS'(i); req_be_i = 4'hF;
        n_checks++;
        if (req_ready_o !== 1'b1) begin n_fails++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready_o); end
      end else begin
        req_valid_i = 1'b0;
      end
      if (rsp_valid_o === 1'b1) begin
        n_checks++;
        if (rsp_we_o !== 1'b0 || rsp_rdata_o !== ref_mem[rcount]) begin
          n_fails++;
          $display("FAIL b2b_data[%0d]: got %h want %h", rcount, rsp_rdata_o, ref_mem[rcount]);
        end
        rcount++;
      end
    end
    n_checks++;
    if (rcount != 16) begin n_fails++; $display("FAIL b2b_count: got %0d want 16", rcount); end
  endtask

  task automatic test_backpressure();
    int nacc = 0; int k = 0; bit have = 1'b0; logic [DBITS-1:0] head = '0;
    rsp_ready_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_i);
      req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = ABITS'(20 + nacc); req_be_i = 4'hF;
      if (req_ready_o === 1'b1) nacc++;
      if (rsp_valid_o === 1'b1) begin
        if (!have) begin
          have = 1'b1; head = rsp_rdata_o;
        end else begin
          n_checks++;
          if (rsp_rdata_o !== head || rsp_we_o !== 1'b0) begin
            n_fails++; $display("FAIL bp_stable: got %h want %h", rsp_rdata_o, head);
          end
        end
      end
    end
    n_checks += 2;
    if (nacc != 3) begin n_fails++; $display("FAIL bp_accepts: got %0d want 3", nacc); end
    if (req_ready_o !== 1'b0) begin n_fails++; $display("FAIL bp_ready_low: got %b want 0", req_ready_o); end
    @(negedge clk_i);
    req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (rsp_valid_o === 1'b1) begin
        n_checks++;
        if (rsp_rdata_o !== ref_mem[20 + k]) begin
          n_fails++; $display("FAIL bp_drain[%0d]: got %h want %h", k, rsp_rdata_o, ref_mem[20 + k]);
        end
        k++;
      end
      @(negedge clk_i);
    end
    n_checks += 2;
    if (k != 3) begin n_fails++; $display("FAIL bp_drain_count: got %0d want 3", k); end
    if (req_ready_o !== 1'b1) begin n_fails++; $display("FAIL bp_ready_back: got %b want 1", req_ready_o); end
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; logic [DBITS-1:0] saved;
    saved = ref_mem[40];
    rsp_ready_i = 1'b0;
    do_req(1'b0, 10'd50, 4'hF, 32'h0);
    do_req(1'b0, 10'd51, 4'hF, 32'h0);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_checks++;
    if (rsp_valid_o !== 1'b1) begin n_fails++; $display("FAIL rm_pre_valid: got %b want 1", rsp_valid_o); end
    rst_ni = 1'b0; req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 10'd40;
    req_be_i = 4'hF; req_wdata_i = 32'hCAFE_F00D;
    #1;
    n_checks++;
    if (ram_we_o !== 1'b0 || req_ready_o !== 1'b0) begin
      n_fails++; $display("FAIL rm_in_reset: got ram_we=%b ready=%b want 0/0", ram_we_o, req_ready_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1; req_valid_i = 1'b0;
    #1;
    n_checks++;
    if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'h0 || req_ready_o !== 1'b1) begin
      n_fails++;
      $display("FAIL rm_after: got valid=%b rdata=%h ready=%b want 0/0/1", rsp_valid_o, rsp_rdata_o, req_ready_o);
    end
    rsp_ready_i = 1'b1;
    do_req(1'b0, 10'd40, 4'hF, 32'h0);
    wait_rsp(ok, lat);
    n_checks++;
    if (!ok || rsp_rdata_o !== saved) begin
      n_fails++; $display("FAIL rm_no_write: got ok=%b rdata=%h want 1/%h", ok, rsp_rdata_o, saved);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      req_valid_i = ($urandom % 4) != 0;
      req_we_i    = 1'($urandom % 2);
      req_addr_i  = ABITS'($urandom_range(0, 31));
      req_be_i    = BBITS'($urandom);
      req_wdata_i = $urandom;
      rsp_ready_i = ($urandom % 3) != 0;
    end
    @(negedge clk_i);
    req_valid_i = 1'b0; rsp_ready_i = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (exp_q.size() == 0 && rsp_valid_o === 1'b0) break;
      @(negedge clk_i);
    end
    n_checks++;
    if (exp_q.size() != 0 || rsp_valid_o !== 1'b0) begin
      n_fails++;
      $display("FAIL rand_drain: got pending=%0d valid=%b want 0/0", exp_q.size(), rsp_valid_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0; preload = 1'b1;
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_be_i = '0; req_wdata_i = '0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 preload = 1'b0;
    test_reset();
    test_write_read();
    test_partial_be();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
